config_stream_tx: RTL

- Transmit end of the fabric configuration word port. Produces the 32-bit WriteData/WriteStrobe/FSM_Reset stream that the fabric configuration FSM consumes.
- Sequence: session activation edge, sync word 0xFAB0_FAB1, then per frame one header word (frame address) followed by NumberOfRows data words, then a desync word.
- Sits between a bitstream source (DMA/ROM/host bridge) and the fabric config port; used for on-chip reconfiguration and as the bench stimulus driver for the config path.

---
 rtl/config_stream_tx.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/config_stream_tx.sv
// ============================================================================
// Module : config_stream_tx
// Brief  : Transmit end of the fabric configuration word port (sync/header/
//          data/desync stream). Optional macro CONFIG_STREAM_TX_PREAMBLE_EN
//          inserts zero padding words ahead of the sync word.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module config_stream_tx #(
    parameter int NUMBER_OF_ROWS     = 16,
    parameter int FRAME_BITS_PER_ROW = 32,
`ifdef CONFIG_STREAM_TX_PREAMBLE_EN
    parameter int PREAMBLE_WORDS     = 4,
`endif
    parameter int DESYNC_FLAG        = 20
) (
    input  logic                          CLK,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [FRAME_BITS_PER_ROW-1:0] cmd_addr,
    input  logic                          cmd_last,
    input  logic                          data_valid,
    output logic                          data_ready,
    input  logic [FRAME_BITS_PER_ROW-1:0] data_in,
    output logic [FRAME_BITS_PER_ROW-1:0] WriteData,
    output logic                          WriteStrobe,
    output logic                          FSM_Reset,
    output logic                          busy,
    output logic                          done,
    output logic                          addr_err
);

    localparam logic [FRAME_BITS_PER_ROW-1:0] c_SYNC_WORD   = FRAME_BITS_PER_ROW'(32'hFAB0_FAB1);
    localparam logic [FRAME_BITS_PER_ROW-1:0] c_DESYNC_WORD = FRAME_BITS_PER_ROW'(1) << DESYNC_FLAG;
    localparam logic [4:0]                    c_ROW_LAST    = 5'(NUMBER_OF_ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ACTIVATE = 3'd1,
`ifdef CONFIG_STREAM_TX_PREAMBLE_EN
        S_PREAMBLE = 3'd7,
`endif
        S_SYNC     = 3'd2,
        S_HEADER   = 3'd3,
        S_DATA     = 3'd4,
        S_DESYNC   = 3'd5,
        S_DONE     = 3'd6
    } state_t;

    state_t                        r_state,     w_next_state;
    logic [4:0]                    r_row_cnt,   w_row_cnt;
    logic                          r_last,      w_last;
    logic [FRAME_BITS_PER_ROW-1:0] r_wdata,     w_wdata;
    logic                          r_strobe,    w_strobe;
    logic                          r_fsm_reset, w_fsm_reset;
    logic                          r_busy,      w_busy;
    logic                          r_done,      w_done;
    logic                          r_addr_err,  w_addr_err;

`ifdef CONFIG_STREAM_TX_PREAMBLE_EN
    localparam int c_PRE_W = (PREAMBLE_WORDS > 1) ? $clog2(PREAMBLE_WORDS) : 1;
    logic [c_PRE_W-1:0] r_pre_cnt, w_pre_cnt;
`endif

    // Handshake readiness depends on state only, so sources see no comb path.
    assign cmd_ready   = (r_state == S_HEADER);
    assign data_ready  = (r_state == S_DATA);
    assign WriteData   = r_wdata;
    assign WriteStrobe = r_strobe;
    assign FSM_Reset   = r_fsm_reset;
    assign busy        = r_busy;
    assign done        = r_done;
    assign addr_err    = r_addr_err;

    always_comb begin
        w_next_state = r_state;
        w_row_cnt    = r_row_cnt;
        w_last       = r_last;
        w_wdata      = r_wdata;
        w_strobe     = 1'b0;
        w_fsm_reset  = r_fsm_reset;
        w_busy       = r_busy;
        w_done       = 1'b0;
        w_addr_err   = 1'b0;
`ifdef CONFIG_STREAM_TX_PREAMBLE_EN
        w_pre_cnt    = r_pre_cnt;
`endif
        case (r_state)
            S_IDLE: begin
                if (start && !abort) begin
                    w_next_state = S_ACTIVATE;
                    w_fsm_reset  = 1'b1;
                    w_busy       = 1'b1;
                end
            end
            S_ACTIVATE: begin
`ifdef CONFIG_STREAM_TX_PREAMBLE_EN
                w_pre_cnt    = c_PRE_W'(PREAMBLE_WORDS - 1);
                w_next_state = S_PREAMBLE;
`else
                w_next_state = S_SYNC;
`endif
            end
`ifdef CONFIG_STREAM_TX_PREAMBLE_EN
            S_PREAMBLE: begin
                w_wdata  = '0;
                w_strobe = 1'b1;
                if (r_pre_cnt == '0) begin
                    w_next_state = S_SYNC;
                end else begin
                    w_pre_cnt = r_pre_cnt - 1'b1;
                end
            end
`endif
            S_SYNC: begin
                w_wdata      = c_SYNC_WORD;
                w_strobe     = 1'b1;
                w_next_state = S_HEADER;
            end
            S_HEADER: begin
                if (cmd_valid) begin
                    // The desync bit is reserved for the end-of-session word.
                    w_wdata      = cmd_addr & ~c_DESYNC_WORD;
                    w_strobe     = 1'b1;
                    w_addr_err   = cmd_addr[DESYNC_FLAG];
                    w_last       = cmd_last;
                    w_row_cnt    = c_ROW_LAST;
                    w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (data_valid) begin
                    w_wdata  = data_in;
                    w_strobe = 1'b1;
                    if (r_row_cnt == 5'd0) begin
                        w_next_state = r_last ? S_DESYNC : S_HEADER;
                    end else begin
                        w_row_cnt = r_row_cnt - 5'd1;
                    end
                end
            end
            S_DESYNC: begin
                w_wdata      = c_DESYNC_WORD;
                w_strobe     = 1'b1;
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_fsm_reset  = 1'b0;
                w_busy       = 1'b0;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // Abort discards any same-cycle handshake and skips desync/done.
        if (abort && (r_state != S_IDLE)) begin
            w_next_state = S_IDLE;
            w_wdata      = r_wdata;
            w_strobe     = 1'b0;
            w_fsm_reset  = 1'b0;
            w_busy       = 1'b0;
            w_done       = 1'b0;
            w_addr_err   = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_row_cnt   <= 5'd0;
            r_last      <= 1'b0;
            r_wdata     <= '0;
            r_strobe    <= 1'b0;
            r_fsm_reset <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_addr_err  <= 1'b0;
`ifdef CONFIG_STREAM_TX_PREAMBLE_EN
            r_pre_cnt   <= '0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_row_cnt   <= w_row_cnt;
            r_last      <= w_last;
            r_wdata     <= w_wdata;
            r_strobe    <= w_strobe;
            r_fsm_reset <= w_fsm_reset;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_addr_err  <= w_addr_err;
`ifdef CONFIG_STREAM_TX_PREAMBLE_EN
            r_pre_cnt   <= w_pre_cnt;
`endif
        end
    end

endmodule

`default_nettype wire
